acc_bank: RTL and testbench

ACC_BANK -- requirements
Module: acc_bank

---
 rtl/acc_bank.sv | 105 ++++++++++
 tb/tb_acc_bank.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/acc_bank.sv
// acc_bank: bank of NUM_ACC independent N-bit accumulators with carry flags.
// One operation per cycle on the selected accumulator; reads are combinational.
module acc_bank #(
    parameter int N       = 15,
    parameter int NUM_ACC = 4,
    parameter int SAT     = 0,
    parameter int SW      = (NUM_ACC > 1) ? $clog2(NUM_ACC) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [SW-1:0] acc_sel,
    input  logic          clr_en,
    input  logic          alu_to_ac,
    input  logic [N-1:0]  alu_out,
    input  logic          write_en,
    input  logic [N-1:0]  datain,
    input  logic          dec_en,
    input  logic          inc_en,
    output logic [N-1:0]  dataout,
    output logic          zero_flag,
    output logic          carry_flag
);

    logic [NUM_ACC-1:0][N-1:0] acc_q, acc_d;
    logic [NUM_ACC-1:0]        cy_q, cy_d;

    logic [NUM_ACC-1:0] hit;
    logic [N-1:0]       rd_acc;
    logic               rd_cy;
    logic               op_en;
    logic [N-1:0]       nxt_acc;
    logic               nxt_cy;
    logic               at_max;
    logic               at_min;

    // A select outside the bank matches no entry, so it reads as zero
    // and no accumulator is written.
    always_comb begin
        hit    = '0;
        rd_acc = '0;
        rd_cy  = 1'b0;
        for (int i = 0; i < NUM_ACC; i++) begin
            if (acc_sel == SW'(i)) begin
                hit[i] = 1'b1;
                rd_acc = acc_q[i];
                rd_cy  = cy_q[i];
            end
        end
    end

    assign at_max = (rd_acc == {N{1'b1}});
    assign at_min = (rd_acc == '0);
    assign op_en  = clr_en | alu_to_ac | write_en | dec_en | inc_en;

    always_comb begin
        nxt_acc = rd_acc;
        nxt_cy  = rd_cy;
        if (clr_en) begin
            nxt_acc = '0;
            nxt_cy  = 1'b0;
        end else if (alu_to_ac) begin
            nxt_acc = alu_out;
            nxt_cy  = 1'b0;
        end else if (write_en) begin
            nxt_acc = datain;
            nxt_cy  = 1'b0;
        end else if (dec_en) begin
            nxt_cy = at_min;
            if (!(at_min && SAT != 0)) begin
                nxt_acc = rd_acc - N'(1);
            end
        end else if (inc_en) begin
            nxt_cy = at_max;
            if (!(at_max && SAT != 0)) begin
                nxt_acc = rd_acc + N'(1);
            end
        end
    end

    always_comb begin
        acc_d = acc_q;
        cy_d  = cy_q;
        for (int i = 0; i < NUM_ACC; i++) begin
            if (hit[i] && op_en) begin
                acc_d[i] = nxt_acc;
                cy_d[i]  = nxt_cy;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q <= '0;
            cy_q  <= '0;
        end else begin
            acc_q <= acc_d;
            cy_q  <= cy_d;
        end
    end

    assign dataout    = rd_acc;
    assign zero_flag  = (rd_acc == '0);
    assign carry_flag = rd_cy;

endmodule

// File: tb/tb_acc_bank.sv
// tb_acc_bank: directed vector table plus hand sequences for saturation,
// out-of-range select and asynchronous reset.
module tb_acc_bank;
    localparam int N = 15;

    localparam logic [4:0] NONE = 5'b00000;
    localparam logic [4:0] INC  = 5'b00001;
    localparam logic [4:0] DEC  = 5'b00010;
    localparam logic [4:0] WR   = 5'b00100;
    localparam logic [4:0] ALU  = 5'b01000;
    localparam logic [4:0] CLR  = 5'b10000;

    logic         clk;
    logic         rst;
    logic [1:0]   acc_sel;
    logic         clr_en, alu_to_ac, write_en, dec_en, inc_en;
    logic [N-1:0] alu_out, datain;
    logic [N-1:0] d0, d1, d2;
    logic         z0, z1, z2, c0, c1, c2;

    int nvec = 0;
    int nmis = 0;

    typedef struct {
        logic [1:0]   sel;
        logic [4:0]   en;
        logic [N-1:0] alu;
        logic [N-1:0] din;
        logic [N-1:0] ed;
        logic         ez;
        logic         ec;
    } vec_t;

    vec_t tbl [23];

    acc_bank #(.N(N), .NUM_ACC(4), .SAT(0)) u_wrap (
        .clk(clk), .rst(rst), .acc_sel(acc_sel),
        .clr_en(clr_en), .alu_to_ac(alu_to_ac), .alu_out(alu_out),
        .write_en(write_en), .datain(datain),
        .dec_en(dec_en), .inc_en(inc_en),
        .dataout(d0), .zero_flag(z0), .carry_flag(c0)
    );

    acc_bank #(.N(N), .NUM_ACC(4), .SAT(1)) u_sat (
        .clk(clk), .rst(rst), .acc_sel(acc_sel),
        .clr_en(clr_en), .alu_to_ac(alu_to_ac), .alu_out(alu_out),
        .write_en(write_en), .datain(datain),
        .dec_en(dec_en), .inc_en(inc_en),
        .dataout(d1), .zero_flag(z1), .carry_flag(c1)
    );

    acc_bank #(.N(N), .NUM_ACC(3), .SAT(0)) u_three (
        .clk(clk), .rst(rst), .acc_sel(acc_sel),
        .clr_en(clr_en), .alu_to_ac(alu_to_ac), .alu_out(alu_out),
        .write_en(write_en), .datain(datain),
        .dec_en(dec_en), .inc_en(inc_en),
        .dataout(d2), .zero_flag(z2), .carry_flag(c2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drv(input logic [1:0] s, input logic [4:0] e,
                       input logic [N-1:0] a, input logic [N-1:0] dn);
        acc_sel   = s;
        clr_en    = e[4];
        alu_to_ac = e[3];
        write_en  = e[2];
        dec_en    = e[1];
        inc_en    = e[0];
        alu_out   = a;
        datain    = dn;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm,
                       input logic [N-1:0] gd, input logic gz, input logic gc,
                       input logic [N-1:0] ed, input logic ez, input logic ec);
        nvec++;
        if (gd !== ed || gz !== ez || gc !== ec) begin
            nmis++;
            $display("FAIL %s: got dout=%h z=%b c=%b, want dout=%h z=%b c=%b",
                     nm, gd, gz, gc, ed, ez, ec);
        end
    endtask

    task automatic rst_pulse();
        @(negedge clk);
        drv(2'd0, NONE, '0, '0);
        rst = 1'b1;
        #2;
        rst = 1'b0;
    endtask

    initial begin
        tbl[0]  = '{2'd2, INC,       15'h0,    15'h0,    15'h0001, 1'b0, 1'b0};
        tbl[1]  = '{2'd2, INC,       15'h0,    15'h0,    15'h0002, 1'b0, 1'b0};
        tbl[2]  = '{2'd2, INC,       15'h0,    15'h0,    15'h0003, 1'b0, 1'b0};
        tbl[3]  = '{2'd0, NONE,      15'h0,    15'h0,    15'h0000, 1'b1, 1'b0};
        tbl[4]  = '{2'd1, NONE,      15'h0,    15'h0,    15'h0000, 1'b1, 1'b0};
        tbl[5]  = '{2'd3, NONE,      15'h0,    15'h0,    15'h0000, 1'b1, 1'b0};
        tbl[6]  = '{2'd2, NONE,      15'h0,    15'h0,    15'h0003, 1'b0, 1'b0};
        tbl[7]  = '{2'd1, WR,        15'h0,    15'h7FFF, 15'h7FFF, 1'b0, 1'b0};
        tbl[8]  = '{2'd1, INC,       15'h0,    15'h0,    15'h0000, 1'b1, 1'b1};
        tbl[9]  = '{2'd1, DEC,       15'h0,    15'h0,    15'h7FFF, 1'b0, 1'b1};
        tbl[10] = '{2'd1, INC,       15'h0,    15'h0,    15'h0000, 1'b1, 1'b1};
        tbl[11] = '{2'd1, INC,       15'h0,    15'h0,    15'h0001, 1'b0, 1'b0};
        tbl[12] = '{2'd3, CLR|ALU|INC, 15'h0123, 15'h0,  15'h0000, 1'b1, 1'b0};
        tbl[13] = '{2'd3, ALU|WR,    15'h0123, 15'h0456, 15'h0123, 1'b0, 1'b0};
        tbl[14] = '{2'd3, WR|INC,    15'h0,    15'h0010, 15'h0010, 1'b0, 1'b0};
        tbl[15] = '{2'd3, WR,        15'h0,    15'h0005, 15'h0005, 1'b0, 1'b0};
        tbl[16] = '{2'd3, DEC|INC,   15'h0,    15'h0,    15'h0004, 1'b0, 1'b0};
        tbl[17] = '{2'd1, DEC,       15'h0,    15'h0,    15'h0000, 1'b1, 1'b0};
        tbl[18] = '{2'd1, DEC,       15'h0,    15'h0,    15'h7FFF, 1'b0, 1'b1};
        tbl[19] = '{2'd1, ALU,       15'h00AA, 15'h0,    15'h00AA, 1'b0, 1'b0};
        tbl[20] = '{2'd2, CLR,       15'h0,    15'h0,    15'h0000, 1'b1, 1'b0};
        tbl[21] = '{2'd3, NONE,      15'h0,    15'h0,    15'h0004, 1'b0, 1'b0};
        tbl[22] = '{2'd1, NONE,      15'h0,    15'h0,    15'h00AA, 1'b0, 1'b0};

        rst = 1'b1;
        drv(2'd0, NONE, '0, '0);
        #3;
        chk("reset_state", d0, z0, c0, 15'h0, 1'b1, 1'b0);
        drv(2'd0, INC, '0, '0);
        tick();
        chk("inc_in_reset", d0, z0, c0, 15'h0, 1'b1, 1'b0);
        @(negedge clk);
        drv(2'd0, NONE, '0, '0);
        rst = 1'b0;

        for (int i = 0; i < 23; i++) begin
            drv(tbl[i].sel, tbl[i].en, tbl[i].alu, tbl[i].din);
            tick();
            chk($sformatf("vec%0d", i), d0, z0, c0,
                tbl[i].ed, tbl[i].ez, tbl[i].ec);
        end

        // saturating vs wrapping at both ends
        rst_pulse();
        drv(2'd0, DEC, '0, '0);
        tick();
        chk("sat_dec_at0", d1, z1, c1, 15'h0, 1'b1, 1'b1);
        chk("wrap_dec_at0", d0, z0, c0, 15'h7FFF, 1'b0, 1'b1);
        drv(2'd0, WR, '0, 15'h7FFF);
        tick();
        chk("sat_load_max", d1, z1, c1, 15'h7FFF, 1'b0, 1'b0);
        drv(2'd0, INC, '0, '0);
        tick();
        chk("sat_inc_atmax", d1, z1, c1, 15'h7FFF, 1'b0, 1'b1);
        chk("wrap_inc_atmax", d0, z0, c0, 15'h0, 1'b1, 1'b1);
        drv(2'd0, DEC, '0, '0);
        tick();
        chk("sat_dec_frommax", d1, z1, c1, 15'h7FFE, 1'b0, 1'b0);

        // out-of-range select on the three-entry bank
        rst_pulse();
        drv(2'd0, WR, '0, 15'h0011);
        tick();
        drv(2'd1, WR, '0, 15'h0022);
        tick();
        drv(2'd2, WR, '0, 15'h0033);
        tick();
        drv(2'd3, WR, '0, 15'h0055);
        tick();
        chk("oor_read", d2, z2, c2, 15'h0, 1'b1, 1'b0);
        chk("inrange_sel3", d0, z0, c0, 15'h0055, 1'b0, 1'b0);
        drv(2'd3, INC, '0, '0);
        tick();
        chk("oor_inc", d2, z2, c2, 15'h0, 1'b1, 1'b0);
        drv(2'd0, NONE, '0, '0);
        #1;
        chk("oor_keep0", d2, z2, c2, 15'h0011, 1'b0, 1'b0);
        acc_sel = 2'd1;
        #1;
        chk("oor_keep1", d2, z2, c2, 15'h0022, 1'b0, 1'b0);
        acc_sel = 2'd2;
        #1;
        chk("oor_keep2", d2, z2, c2, 15'h0033, 1'b0, 1'b0);

        // asynchronous reset between edges, with inc held high
        rst_pulse();
        for (int s = 0; s < 4; s++) begin
            drv(2'(s), WR, '0, 15'h1234);
            tick();
        end
        drv(2'd0, NONE, '0, '0);
        for (int s = 0; s < 4; s++) begin
            acc_sel = 2'(s);
            #1;
            chk($sformatf("load_sel%0d", s), d0, z0, c0, 15'h1234, 1'b0, 1'b0);
        end
        @(negedge clk);
        drv(2'd0, INC, '0, '0);
        #1;
        rst = 1'b1;
        #1;
        chk("async_sel0", d0, z0, c0, 15'h0, 1'b1, 1'b0);
        acc_sel = 2'd3;
        #1;
        chk("async_sel3", d0, z0, c0, 15'h0, 1'b1, 1'b0);
        chk("async_sat_sel3", d1, z1, c1, 15'h0, 1'b1, 1'b0);
        tick();
        chk("inc_held_rst", d0, z0, c0, 15'h0, 1'b1, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        tick();
        chk("first_after_rst", d0, z0, c0, 15'h0001, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
